// File: rtl/fire_scheduler.sv
// fire_scheduler: round-robin fire arbiter with per-mode cooldown, ammo tracking and timed reload
module fire_scheduler #(
    parameter int AMMO_MAX   = 8,
    parameter int CD_SPRAY   = 4,
    parameter int CD_NARROW  = 2,
    parameter int RELOAD_CYC = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [3:0]  angle0,
    input  logic [3:0]  angle1,
    input  logic [1:0]  mode0,
    input  logic [1:0]  mode1,
    input  logic        reload_req,
    output logic        fire,
    output logic [3:0]  fire_angle,
    output logic [1:0]  fire_mode,
    output logic        ack0,
    output logic        ack1,
    output logic [3:0]  ammo,
    output logic        busy,
    output logic [1:0]  state,
    output logic [15:0] shots_fired
);
    typedef enum logic [1:0] {IDLE, ISSUE, COOLDOWN, RELOAD} state_t;

    localparam logic [3:0] AMMO_FULL   = 4'(AMMO_MAX);
    localparam logic [3:0] CD_S_LAST   = 4'(CD_SPRAY - 1);
    localparam logic [3:0] CD_N_LAST   = 4'(CD_NARROW - 1);
    localparam logic [7:0] RELOAD_LAST = 8'(RELOAD_CYC - 1);

    state_t     cur, nxt;
    logic [3:0] cd_cnt;
    logic [7:0] rl_cnt;
    logic       last_gnt;
    logic       v0, v1, win1, grant, cd_done, rl_done;

    assign state = cur;
    assign busy  = cur != IDLE;

    // Request qualification, round-robin winner and next-state selection
    always_comb begin
        v0      = req0 && !mode0[1];
        v1      = req1 && !mode1[1];
        win1    = v1 && (!v0 || !last_gnt);
        cd_done = cd_cnt == (fire_mode[0] ? CD_N_LAST : CD_S_LAST);
        rl_done = rl_cnt == RELOAD_LAST;
        grant   = 1'b0;
        nxt     = cur;
        case (cur)
            IDLE: begin
                if (ammo == 4'd0 || (reload_req && ammo < AMMO_FULL)) begin
                    nxt = RELOAD;
                end else if (v0 || v1) begin
                    nxt   = ISSUE;
                    grant = 1'b1;
                end
            end
            ISSUE:    nxt = COOLDOWN;
            COOLDOWN: nxt = cd_done ? IDLE : COOLDOWN;
            RELOAD:   nxt = rl_done ? IDLE : RELOAD;
            default:  nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cur <= IDLE;
        else          cur <= nxt;
    end

    // Cooldown and reload counters run only in their own state, so they are zero on entry
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cd_cnt <= 4'd0;
            rl_cnt <= 8'd0;
        end else begin
            cd_cnt <= (cur == COOLDOWN) ? cd_cnt + 4'd1 : 4'd0;
            rl_cnt <= (cur == RELOAD) ? rl_cnt + 8'd1 : 8'd0;
        end
    end

    // Grant side effects land on the edge entering ISSUE so fire/ack/ammo are visible during ISSUE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fire        <= 1'b0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            fire_angle  <= 4'd0;
            fire_mode   <= 2'd0;
            ammo        <= AMMO_FULL;
            shots_fired <= 16'd0;
            last_gnt    <= 1'b1;
        end else begin
            fire <= grant;
            ack0 <= grant && !win1;
            ack1 <= grant && win1;
            if (grant) begin
                fire_angle  <= win1 ? angle1 : angle0;
                fire_mode   <= win1 ? mode1 : mode0;
                ammo        <= ammo - 4'd1;
                shots_fired <= shots_fired + {15'd0, shots_fired != 16'hFFFF};
                last_gnt    <= win1;
            end else if (cur == RELOAD && rl_done) begin
                ammo <= AMMO_FULL;
            end
        end
    end
endmodule

// File: doc/fire_scheduler.md
FIRE_SCHEDULER -- requirements
Module: fire_scheduler

Interface
REQ-001 The block SHALL provide parameter AMMO_MAX, default 8, shots per magazine (1..15).
REQ-002 The block SHALL provide parameter CD_SPRAY, default 4, cooldown cycles after a mode 2'b00 shot (1..15).
REQ-003 The block SHALL provide parameter CD_NARROW, default 2, cooldown cycles after a mode 2'b01 shot (1..15).
REQ-004 The block SHALL provide parameter RELOAD_CYC, default 16, reload duration in cycles (1..255).
REQ-005 The ports SHALL be as follows, with one clock and an asynchronous, active-low reset:
- clk  in  1  clock; all state changes on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- req0 / req1  in  1  fire request from requester 0 (player) / requester 1 (turret); held until acked
- angle0 / angle1  in  4  requested fire angle
- mode0 / mode1  in  2  requested fire mode
- reload_req  in  1  manual reload request
- fire  out  1  one-cycle fire strobe to the enemy controller
- fire_angle  out  4  angle qualified by fire
- fire_mode  out  2  mode qualified by fire
- ack0 / ack1  out  1  one-cycle grant acknowledge
- ammo  out  4  remaining shots
- busy  out  1  high whenever state != IDLE
- state  out  2  IDLE=0, ISSUE=1, COOLDOWN=2, RELOAD=3
- shots_fired  out  16  total shots issued

Function
REQ-006 A request SHALL be valid only when reqX=1 and modeX is 2'b00 or 2'b01; a request with mode 2'b10 or 2'b11 SHALL be ignored and never acked.
REQ-007 In IDLE, reload_req=1 with ammo<AMMO_MAX SHALL have priority over valid requests: next state RELOAD.
REQ-008 In IDLE with ammo==0, next state SHALL be RELOAD regardless of requests.
REQ-009 Otherwise, in IDLE with a valid request, the arbiter SHALL grant round-robin:
- if only one requester is valid, it wins
- if both are valid, the requester not granted last wins
- the last-grant pointer resets to 1, so req0 wins the first tie
REQ-010 On a grant, the winner's angle and mode SHALL be latched and the next state SHALL be ISSUE.
REQ-011 ISSUE SHALL last exactly one cycle, and in that cycle:
- fire=1, with fire_angle/fire_mode equal to the latched values
- ackX=1 for the winner only
- ammo decrements by 1
- shots_fired increments, saturating at 16'hFFFF
REQ-012 After ISSUE, COOLDOWN SHALL last exactly CD_SPRAY or CD_NARROW cycles, selected by the latched mode.
REQ-013 After COOLDOWN, next state SHALL be IDLE.
REQ-014 RELOAD SHALL last exactly RELOAD_CYC cycles, then load ammo=AMMO_MAX and return to IDLE.
REQ-015 fire, ack0 and ack1 SHALL be registered and high only in ISSUE; fire_angle and fire_mode SHALL hold their last value outside ISSUE.
REQ-016 Grant latency SHALL be one cycle: a valid request sampled in IDLE at edge N produces fire/ack during cycle N+1.
REQ-017 Minimum fire-to-fire spacing SHALL be C+2 cycles (1 ISSUE + C cooldown + 1 IDLE arbitration): 6 for spray and 4 for narrow at default parameters.
REQ-018 Requests and reload_req arriving outside IDLE SHALL be ignored until IDLE; a request dropped before IDLE SHALL leave no effect.
REQ-019 The requester not granted SHALL keep waiting with no ack, and SHALL win the next arbitration if still valid.
REQ-020 ammo SHALL never underflow; ISSUE is unreachable with ammo==0.
REQ-021 reload_req when ammo==AMMO_MAX SHALL be ignored.
REQ-022 The cooldown and reload counters SHALL be internal, sized for the maximum parameter values, and SHALL reset on entry to their state.

Reset
REQ-023 On reset_n=0, asynchronously:
- state=IDLE, fire=0, ack0=0, ack1=0
- fire_angle=0, fire_mode=0
- ammo=AMMO_MAX, shots_fired=0
- last-grant pointer=1, internal counters=0
REQ-024 Reset asserted mid-ISSUE, COOLDOWN or RELOAD SHALL abort the operation immediately, with no fire pulse after release.
REQ-025 The first grant SHALL be possible at the first rising edge after reset_n deasserts.

Verification
REQ-026 Single shot: req0=1, angle0=5, mode0=00 -> next cycle fire=1, fire_angle=5, fire_mode=00, ack0=1, ammo=7; busy for 4 cooldown cycles; IDLE afterwards.
REQ-027 Tie arbitration: req0 and req1 held high, mode 01 -> acks alternate ack0, ack1, ack0, ... with fire pulses 4 cycles apart.
REQ-028 Ammo exhaustion: req0 held, mode 01 -> 8 fires, then RELOAD for 16 cycles with no fire, then ammo=8 and firing resumes.
REQ-029 Invalid and manual reload: mode0=2'b10 held -> no ack and no fire; with ammo=3 and reload_req=1 in IDLE -> RELOAD, then ammo=8.
REQ-030 Reset mid-operation: reset_n pulsed low during COOLDOWN after 3 shots -> ammo=8, shots_fired=0, state=IDLE; next request grants req0 first.
